// File: rtl/uart_rx_buffer_if.sv
// rtl/uart_rx_buffer_if.sv - serial input, pop/clear controls and FIFO/status outputs of the UART receive buffer
interface uart_rx_buffer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_serial;
    logic          rd_en;
    logic          clr_flags;
    logic [31:0]   rdata;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          byte_valid;
    logic          framing_err;
    logic          overflow;

    // Driver side: owns the serial line and the pop/clear controls
    modport master (
        output rx_serial, rd_en, clr_flags,
        input  rdata, empty, full, count, byte_valid, framing_err, overflow
    );

    // Receiver side
    modport slave (
        input  rx_serial, rd_en, clr_flags,
        output rdata, empty, full, count, byte_valid, framing_err, overflow
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver assembling little-endian 32-bit words into a FWFT FIFO
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic            clk_uart,
    input  logic            reset,
    uart_rx_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchroniser and receiver state
    logic [1:0]       r_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bidx;
    logic [7:0]       r_sh;

    // Word assembly and status
    logic [1:0]       r_bi;
    logic [23:0]      r_word;
    logic             r_byte_valid;
    logic             r_framing_err;
    logic             r_overflow;

    // FIFO storage
    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Combinational next-state and events
    logic             w_rxs;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       w_bidx_nx;
    logic [7:0]       w_sh_nx;
    logic             w_good;
    logic             w_ferr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_ovf_set;
    logic [31:0]      w_word_done;

    assign w_rxs = r_sync[1];

    // Two-flop synchroniser on the asynchronous serial line; idles high
    always_ff @(posedge clk_uart) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rx_serial};
        end
    end

    // Receiver state register
    always_ff @(posedge clk_uart) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bidx  <= w_bidx_nx;
            r_sh    <= w_sh_nx;
        end
    end

    // Receiver next-state: half-bit start check, mid-bit data and stop sampling
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bidx_nx  = r_bidx;
        w_sh_nx    = r_sh;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nx = S_START;
                    w_cnt_nx   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nx = '0;
                    if (!w_rxs) begin
                        w_state_nx = S_DATA;
                        w_bidx_nx  = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nx = '0;
                    w_sh_nx  = {w_rxs, r_sh[7:1]};
                    if (r_bidx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bidx_nx = r_bidx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                    if (w_rxs) begin
                        w_good = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == COUNT_FULL);
    assign w_word_done = {r_sh, r_word};
    assign w_push      = w_good && (r_bi == 2'd3);
    assign w_pop       = bus.rd_en && !w_empty;
    // A pop on the same edge frees the slot the push needs
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;

    // Byte placement into the word, byte_valid pulse and sticky flags
    always_ff @(posedge clk_uart) begin
        if (reset) begin
            r_bi          <= '0;
            r_word        <= '0;
            r_byte_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_byte_valid <= w_good;
            if (w_good) begin
                case (r_bi)
                    2'd0:    r_word[7:0]   <= r_sh;
                    2'd1:    r_word[15:8]  <= r_sh;
                    2'd2:    r_word[23:16] <= r_sh;
                    default: ;
                endcase
                r_bi <= r_bi + 2'd1;
            end else if (w_ferr) begin
                // A bad frame poisons the whole partial word
                r_bi <= '0;
            end

            if (w_ferr) begin
                r_framing_err <= 1'b1;
            end else if (bus.clr_flags) begin
                r_framing_err <= 1'b0;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Word FIFO: pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_uart) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_word_done;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    assign bus.rdata       = r_mem[r_rd_ptr];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.byte_valid  = r_byte_valid;
    assign bus.framing_err = r_framing_err;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer with a byte/word reference model
module tb_uart_rx_buffer;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic reset;

    uart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_uart(clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: words the FIFO should hold, partial word, sticky flags,
    // and the number of byte_valid pulses still owed by the DUT
    logic [31:0] exp_q[$];
    logic [31:0] m_acc;
    int          m_nb;
    logic        m_ferr;
    logic        m_ovf;
    int          exp_bv;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_acc  = '0;
        m_nb   = 0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        exp_bv = 0;
    endtask

    // Monitor: consumes byte_valid pulses and checks every popped word
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.byte_valid) begin
                n_checks++;
                if (exp_bv == 0) begin
                    n_err++;
                    $display("FAIL byte_valid: got unexpected pulse expected none");
                end else begin
                    exp_bv--;
                end
            end
            if (bus.rd_en) begin
                if (exp_q.size() == 0) begin
                    chk("empty_on_rd", 32'(bus.empty), 32'd1);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    chk("rd_nonempty", 32'(bus.empty), 32'd0);
                    chk("rdata_pop", bus.rdata, w);
                end
            end
        end
    end

    task automatic status_checks(string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
        chk({tag, "_full"}, 32'(bus.full), 32'(exp_q.size() == DEPTH));
        chk({tag, "_framing_err"}, 32'(bus.framing_err), 32'(m_ferr));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, "_bv_owed"}, 32'(exp_bv), 32'd0);
    endtask

    // Drives one full 8N1 frame starting just after a rising edge; optional pop
    // held across the stop-sample edge (start driven after edge E0, stop sampled at E0+155)
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        if (stop) exp_bv++;
        for (int k = 0; k < FRAME; k++) begin
            int bit_no;
            bit_no = k / CPB;
            if (bit_no == 0)      bus.rx_serial = 1'b0;
            else if (bit_no <= 8) bus.rx_serial = b[bit_no-1];
            else                  bus.rx_serial = stop;
            bus.rd_en = pop_at_stop && (k == 9 * CPB + CPB / 2 + 2);
            @(posedge clk);
            #1;
        end
        bus.rx_serial = 1'b1;
        bus.rd_en     = 1'b0;
        if (stop) begin
            m_acc[8*m_nb +: 8] = b;
            m_nb++;
            if (m_nb == 4) begin
                m_nb = 0;
                if (exp_q.size() < DEPTH) exp_q.push_back(m_acc);
                else                      m_ovf = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
            m_nb   = 0;
        end
        status_checks("frame");
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1, 1'b0);
    endtask

    task automatic pop_word();
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        chk("pop_count", 32'(bus.count), 32'(exp_q.size()));
    endtask

    task automatic clear_flags();
        bus.clr_flags = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_flags = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        chk("clr_framing_err", 32'(bus.framing_err), 32'd0);
        chk("clr_overflow", 32'(bus.overflow), 32'd0);
    endtask

    task automatic reset_checks();
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_framing_err", 32'(bus.framing_err), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.rx_serial = 1'b1;
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: four bytes back-to-back form one little-endian word
        send_frame(8'h78, 1'b1, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        chk("t1_rdata", bus.rdata, 32'h12345678);
        pop_word();
        chk("t1_empty_after_pop", 32'(bus.empty), 32'd1);

        // 2: short low glitch is rejected, then a normal byte
        bus.rx_serial = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx_serial = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        status_checks("glitch");
        send_frame(8'hA5, 1'b1, 1'b0);

        // 3: bad stop bit discards the partial word
        send_frame(8'h3C, 1'b0, 1'b0);
        send_word(32'h04030201);
        chk("t3_rdata", bus.rdata, 32'h04030201);
        pop_word();
        clear_flags();

        // 4: overflow on the fifth word with no reads
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        chk("t4_full", 32'(bus.full), 32'd1);
        send_word(32'h55555555);
        chk("t4_overflow", 32'(bus.overflow), 32'd1);
        repeat (4) pop_word();
        clear_flags();

        // 5: pop coinciding with word completion while full
        send_word(32'h66666666);
        send_word(32'h77777777);
        send_word(32'h88888888);
        send_word(32'h99999999);
        send_frame(8'hD0, 1'b1, 1'b0);
        send_frame(8'hC1, 1'b1, 1'b0);
        send_frame(8'hB2, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1);
        chk("t5_count", 32'(bus.count), 32'd4);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        repeat (4) pop_word();

        // 6: reset in the middle of the second byte's data bits
        send_frame(8'h5A, 1'b0, 1'b0);
        send_word(32'hCAFEF00D);
        send_frame(8'h99, 1'b1, 1'b0);
        for (int k = 0; k < 4 * CPB; k++) begin
            bus.rx_serial = (k < CPB) ? 1'b0 : k[4];
            @(posedge clk);
            #1;
        end
        reset         = 1'b1;
        bus.rx_serial = 1'b1;
        @(posedge clk);
        #1;
        reset_checks();
        model_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_word(32'hDEADBEEF);
        chk("t6_rdata", bus.rdata, 32'hDEADBEEF);
        pop_word();

        // Random traffic: bytes, occasional bad stop bits, pops and flag clears
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, $urandom_range(0, 9) != 0, 1'b0);
            if ($urandom_range(0, 3) == 0) pop_word();
            if ($urandom_range(0, 7) == 0) clear_flags();
        end
        while (exp_q.size() > 0) pop_word();
        pop_word();
        chk("final_bv_owed", 32'(exp_bv), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
